if_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core. Sits directly upstream of the load-use hazard unit and the ID stage.
- Generates the PC and issues requests to instruction memory. Captures returned instructions into IF/ID, presenting `ifid_ir` to the hazard unit.
- Obeys the hazard unit's `stall` (hold IF/ID, stop fetching) and EX-stage redirects (flush, re-steer PC).

---
 rtl/core_pkg.sv | 6 +
 rtl/ifid_pipe_reg.sv | 35 +++
 rtl/if_fetch_stage.sv | 104 ++++++++++
 tb/tb_if_fetch_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared widths, constants and fetch FSM encoding for the RV32I core
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/ifid_pipe_reg.sv
// ifid_pipe_reg: IF/ID pipeline register, priority flush > stall > load > bubble
module ifid_pipe_reg
  import core_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         stall,
  input  logic         load_valid,
  input  logic [W-1:0] load_pc,
  input  logic [W-1:0] load_ir,
  output logic         valid,
  output logic [W-1:0] pc,
  output logic [W-1:0] ir
);
  logic         r_valid;
  logic [W-1:0] r_pc;
  logic [W-1:0] r_ir;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_ir    <= W'(NOP_INSTR);
    end else if (!stall) begin
      r_valid <= load_valid;
      r_ir    <= load_valid ? load_ir : W'(NOP_INSTR);
      if (load_valid) r_pc <= load_pc;
    end
  end
  assign valid = r_valid;
  assign pc    = r_pc;
  assign ir    = r_ir;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC generation, single-outstanding imem fetch FSM, one-entry
// stall buffer and IF/ID register for the 5-stage RV32I core
module if_fetch_stage
  import core_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_ir
);
  fetch_state_t    r_state, w_state_n;
  logic [XLEN-1:0] r_pc, w_pc_n;
  logic            r_kill, w_kill_n;
  logic [XLEN-1:0] r_buf_pc, r_buf_ir;
  logic [XLEN-1:0] w_redir_pc, w_pc_m4;
  logic            w_rsp_ok, w_wait_load, w_buf_cap, w_drain, w_load;
  logic [XLEN-1:0] w_load_pc, w_load_ir;
  assign w_redir_pc  = redirect_pc & ~XLEN'(3);
  // r_pc already points past the in-flight fetch, so its own PC is r_pc-4
  assign w_pc_m4     = r_pc - XLEN'(4);
  assign w_rsp_ok    = (r_state == WAIT) && imem_rvalid && !r_kill && !redirect_valid;
  assign w_wait_load = w_rsp_ok && (!stall || !ifid_valid);
  assign w_buf_cap   = w_rsp_ok && stall && ifid_valid;
  assign w_drain     = (r_state == HOLD) && !redirect_valid && !stall;
  assign w_load      = w_wait_load || w_drain;
  assign w_load_pc   = w_drain ? r_buf_pc : w_pc_m4;
  assign w_load_ir   = w_drain ? r_buf_ir : imem_rdata;
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_kill_n  = r_kill;
    case (r_state)
      IDLE: w_state_n = REQ;
      REQ: begin
        if (imem_gnt) begin
          w_pc_n    = redirect_valid ? w_redir_pc : r_pc + XLEN'(4);
          w_kill_n  = redirect_valid;
          w_state_n = WAIT;
        end else if (redirect_valid) begin
          w_pc_n = w_redir_pc;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_pc_n   = w_redir_pc;
          w_kill_n = 1'b1;
        end
        if (imem_rvalid) begin
          w_kill_n  = 1'b0;
          w_state_n = w_buf_cap ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (redirect_valid) w_pc_n = w_redir_pc;
        if (redirect_valid || !stall) w_state_n = REQ;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_kill   <= 1'b0;
      r_buf_pc <= '0;
      r_buf_ir <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_kill  <= w_kill_n;
      if (w_buf_cap) begin
        r_buf_pc <= w_pc_m4;
        r_buf_ir <= imem_rdata;
      end
    end
  end
  assign imem_req  = (r_state == REQ);
  assign imem_addr = r_pc;
  // an empty IF/ID must still accept a load while the hazard unit stalls
  ifid_pipe_reg #(.W(XLEN)) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .stall      (stall && ifid_valid),
    .load_valid (w_load),
    .load_pc    (w_load_pc),
    .load_ir    (w_load_ir),
    .valid      (ifid_valid),
    .pc         (ifid_pc),
    .ir         (ifid_ir)
  );
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of fetch FSM, IF/ID, stall, redirect, wrap and reset
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  logic        clk = 0, rst_n = 0, stall = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_ir;
  logic        z = 0;
  logic [31:0] zw = 0;
  logic        req2, gnt2, rv2 = 0, g2_d = 0, v2;
  logic [31:0] addr2, pc2, ir2;
  int          n_chk = 0, n_fail = 0;
  logic        gnt_en = 1, pend = 0, granted24 = 0;
  int          lat = 1, cnt = 0;
  logic [31:0] gaddr = 0, pdata = 0;
  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_ir(ifid_ir)
  );
  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(z), .redirect_valid(z),
    .redirect_pc(zw), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(gnt2), .imem_rvalid(rv2), .imem_rdata(zw),
    .ifid_valid(v2), .ifid_pc(pc2), .ifid_ir(ir2)
  );
  assign gnt2 = req2;
  always #5 clk = ~clk;
  // memory model: updates just after each negedge, response data = addr ^ K after lat cycles
  always @(negedge clk) begin
    #1;
    if (imem_gnt) begin
      pend  = 1;
      cnt   = lat;
      pdata = gaddr ^ K;
    end
    imem_rvalid = 0;
    if (pend) begin
      if (cnt <= 1) begin
        imem_rvalid = 1;
        imem_rdata  = pdata;
        pend        = 0;
      end else cnt--;
    end
    imem_gnt = gnt_en && imem_req;
    if (imem_gnt) begin
      gaddr = imem_addr;
      if (imem_addr == 32'd24) granted24 = 1;
    end
  end
  always @(negedge clk) begin
    #1;
    rv2  = g2_d;
    g2_d = req2;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) tick;
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_valid", {31'd0, ifid_valid}, 0);
    chk("rst_pc", ifid_pc, 0);
    chk("rst_ir", ifid_ir, NOP);
    rst_n = 1;
    tick;
    chk("s_req0", {31'd0, imem_req}, 1);
    chk("s_addr0", imem_addr, 0);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    tick;
    chk("s_wait_req", {31'd0, imem_req}, 0);
    chk("s_nop_first", ifid_ir, NOP);
    chk("s_inv_first", {31'd0, ifid_valid}, 0);
    tick;
    chk("s_v0", {31'd0, ifid_valid}, 1);
    chk("s_pc0", ifid_pc, 0);
    chk("s_ir0", ifid_ir, K);
    chk("s_addr4", imem_addr, 4);
    chk("wrap_addr1", addr2, 0);
    chk("wrap_ifid_pc", pc2, 32'hFFFF_FFFC);
    tick;
    chk("s_bubble", {31'd0, ifid_valid}, 0);
    tick;
    chk("s_pc4", ifid_pc, 4);
    chk("s_ir4", ifid_ir, K ^ 32'd4);
    chk("s_addr8", imem_addr, 8);
    tick;
    tick;
    chk("s_pc8", ifid_pc, 8);
    chk("s_ir8", ifid_ir, K ^ 32'd8);
    chk("s_addr12", imem_addr, 12);
    stall = 1;
    tick;
    chk("st_pc8_a", ifid_pc, 8);
    chk("st_req_a", {31'd0, imem_req}, 0);
    tick;
    chk("st_pc8_b", ifid_pc, 8);
    chk("st_v_b", {31'd0, ifid_valid}, 1);
    chk("st_hold_dut", {30'd0, dut.r_state}, 3);
    tick;
    chk("st_pc8_c", ifid_pc, 8);
    chk("st_req_c", {31'd0, imem_req}, 0);
    stall = 0;
    tick;
    chk("st_pc12", ifid_pc, 12);
    chk("st_ir12", ifid_ir, K ^ 32'd12);
    chk("st_addr16", imem_addr, 16);
    chk("st_req16", {31'd0, imem_req}, 1);
    tick;
    tick;
    chk("s_pc16", ifid_pc, 16);
    chk("s_addr20", imem_addr, 20);
    lat = 2;
    tick;
    redirect_valid = 1;
    redirect_pc = 32'h100;
    tick;
    redirect_valid = 0;
    lat = 1;
    chk("rw_flush_v", {31'd0, ifid_valid}, 0);
    chk("rw_flush_ir", ifid_ir, NOP);
    chk("rw_flush_pc", ifid_pc, 0);
    tick;
    chk("rw_drop_v", {31'd0, ifid_valid}, 0);
    chk("rw_addr100", imem_addr, 32'h100);
    chk("rw_req", {31'd0, imem_req}, 1);
    tick;
    chk("rw_drop_v2", {31'd0, ifid_valid}, 0);
    tick;
    chk("rw_v100", {31'd0, ifid_valid}, 1);
    chk("rw_pc100", ifid_pc, 32'h100);
    chk("rw_ir100", ifid_ir, K ^ 32'h100);
    stall = 1;
    tick;
    tick;
    chk("rs_hold_req", {31'd0, imem_req}, 0);
    chk("rs_hold_pc", ifid_pc, 32'h100);
    redirect_valid = 1;
    redirect_pc = 32'h43;
    tick;
    redirect_valid = 0;
    stall = 0;
    chk("rs_v", {31'd0, ifid_valid}, 0);
    chk("rs_ir", ifid_ir, NOP);
    chk("rs_addr40", imem_addr, 32'h40);
    chk("rs_req", {31'd0, imem_req}, 1);
    tick;
    gnt_en = 0;
    tick;
    chk("rs_pc40", ifid_pc, 32'h40);
    chk("rs_ir40", ifid_ir, K ^ 32'h40);
    chk("bp_addr44", imem_addr, 32'h44);
    redirect_valid = 1;
    redirect_pc = 32'd24;
    tick;
    redirect_valid = 0;
    chk("bp_addr24_a", imem_addr, 24);
    chk("bp_req_a", {31'd0, imem_req}, 1);
    tick;
    chk("bp_addr24_b", imem_addr, 24);
    redirect_valid = 1;
    redirect_pc = 32'h80;
    tick;
    redirect_valid = 0;
    chk("bp_addr80_a", imem_addr, 32'h80);
    chk("bp_req_b", {31'd0, imem_req}, 1);
    tick;
    chk("bp_addr80_b", imem_addr, 32'h80);
    gnt_en = 1;
    tick;
    chk("bp_wait", {31'd0, imem_req}, 0);
    tick;
    chk("bp_pc80", ifid_pc, 32'h80);
    chk("bp_ir80", ifid_ir, K ^ 32'h80);
    chk("bp_no24", {31'd0, granted24}, 0);
    lat = 3;
    tick;
    chk("mr_wait", {31'd0, imem_req}, 0);
    rst_n = 0;
    tick;
    chk("mr_v", {31'd0, ifid_valid}, 0);
    chk("mr_pc", ifid_pc, 0);
    chk("mr_ir", ifid_ir, NOP);
    chk("mr_req", {31'd0, imem_req}, 0);
    rst_n = 1;
    tick;
    chk("mr_addr0", imem_addr, 0);
    chk("mr_req1", {31'd0, imem_req}, 1);
    chk("mr_v_a", {31'd0, ifid_valid}, 0);
    tick;
    chk("mr_late_ign", {31'd0, ifid_valid}, 0);
    tick;
    chk("mr_v_c", {31'd0, ifid_valid}, 0);
    tick;
    chk("mr_v_d", {31'd0, ifid_valid}, 0);
    tick;
    chk("mr_v_load", {31'd0, ifid_valid}, 1);
    chk("mr_pc0", ifid_pc, 0);
    chk("mr_ir0", ifid_ir, K);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
